// File: rtl/load_queue.sv
// In-order load buffer: captures loads at dispatch, snoops the CDB for base operands and
// issues one word read at a time from the head. Optional macro: LOAD_QUEUE_MISALIGN_EN.
`timescale 1ns / 1ps

module load_queue #(
    parameter int unsigned ENTRIES = 4,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned XLEN    = 32
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    input  logic                         flush_in,

    input  logic                         disp_valid_in,
    output logic                         disp_ready_out,
    input  logic [TAG_W-1:0]             disp_tag_in,
    input  logic                         disp_base_rdy_in,
    input  logic [XLEN-1:0]              disp_base_in,
    input  logic [TAG_W-1:0]             disp_base_tag_in,
    input  logic [XLEN-1:0]              disp_imm_in,
    input  logic [2:0]                   disp_funct3_in,

    input  logic                         cdb_valid_in,
    input  logic [TAG_W-1:0]             cdb_tag_in,
    input  logic [XLEN-1:0]              cdb_data_in,

    output logic                         mem_req_valid_out,
    input  logic                         mem_req_ready_in,
    output logic [XLEN-1:0]              mem_addr_out,
    input  logic                         mem_resp_valid_in,
    input  logic [XLEN-1:0]              mem_resp_data_in,

    output logic                         res_valid_out,
    input  logic                         res_ready_in,
    output logic [TAG_W-1:0]             res_tag_out,
    output logic [XLEN-1:0]              res_data_out,
`ifdef LOAD_QUEUE_MISALIGN_EN
    output logic                         res_misalign_out,
`endif
    output logic [$clog2(ENTRIES+1)-1:0] count_out
);

    localparam int unsigned PtrW = $clog2(ENTRIES);
    localparam int unsigned CntW = $clog2(ENTRIES + 1);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StResp,
        StWb,
        StDrain
    } state_e;

    // Entry storage
    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [ENTRIES-1:0] rdy_q, rdy_d;
    logic [TAG_W-1:0]   tag_q   [ENTRIES];
    logic [TAG_W-1:0]   tag_d   [ENTRIES];
    logic [TAG_W-1:0]   btag_q  [ENTRIES];
    logic [TAG_W-1:0]   btag_d  [ENTRIES];
    logic [XLEN-1:0]    base_q  [ENTRIES];
    logic [XLEN-1:0]    base_d  [ENTRIES];
    logic [XLEN-1:0]    imm_q   [ENTRIES];
    logic [XLEN-1:0]    imm_d   [ENTRIES];
    logic [2:0]         f3_q    [ENTRIES];
    logic [2:0]         f3_d    [ENTRIES];

    logic [PtrW-1:0]    head_q, head_d;
    logic [PtrW-1:0]    tail_q, tail_d;
    logic [CntW-1:0]    count_q, count_d;
    state_e             state_q, state_d;

    logic               mem_req_valid_q, mem_req_valid_d;
    logic [XLEN-1:0]    mem_addr_q, mem_addr_d;
    logic               res_valid_q, res_valid_d;
    logic [TAG_W-1:0]   res_tag_q, res_tag_d;
    logic [XLEN-1:0]    res_data_q, res_data_d;
`ifdef LOAD_QUEUE_MISALIGN_EN
    logic               res_misalign_q, res_misalign_d;
`endif

    logic               disp_fire;
    logic               pop;
    logic [XLEN-1:0]    head_addr;

    // Byte/half/word extraction from an aligned memory word.
    function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] word,
                                                input logic [1:0]      off,
                                                input logic [2:0]      f3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [XLEN-1:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[16 +: 16] : word[0 +: 16];
        case (f3)
            3'b000:  r = {{(XLEN-8){b[7]}}, b};
            3'b100:  r = {{(XLEN-8){1'b0}}, b};
            3'b001:  r = {{(XLEN-16){h[15]}}, h};
            3'b101:  r = {{(XLEN-16){1'b0}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

`ifdef LOAD_QUEUE_MISALIGN_EN
    function automatic logic misaligned(input logic [1:0] off, input logic [2:0] f3);
        return ((f3 == 3'b001 || f3 == 3'b101) && off[0]) || (f3 == 3'b010 && off != 2'b00);
    endfunction
`endif

    assign disp_ready_out = (count_q < CntW'(ENTRIES));
    assign disp_fire      = disp_valid_in && disp_ready_out && !flush_in;
    assign pop            = (state_q == StWb) && res_ready_in && !flush_in;
    assign head_addr      = base_q[head_q] + imm_q[head_q];

    always_comb begin
        valid_d         = valid_q;
        rdy_d           = rdy_q;
        tag_d           = tag_q;
        btag_d          = btag_q;
        base_d          = base_q;
        imm_d           = imm_q;
        f3_d            = f3_q;
        head_d          = head_q;
        tail_d          = tail_q;
        count_d         = count_q;
        state_d         = state_q;
        mem_req_valid_d = mem_req_valid_q;
        mem_addr_d      = mem_addr_q;
        res_valid_d     = res_valid_q;
        res_tag_d       = res_tag_q;
        res_data_d      = res_data_q;
`ifdef LOAD_QUEUE_MISALIGN_EN
        res_misalign_d  = res_misalign_q;
`endif

        for (int i = 0; i < ENTRIES; i++) begin
            if (cdb_valid_in && valid_q[i] && !rdy_q[i] && btag_q[i] == cdb_tag_in) begin
                rdy_d[i]  = 1'b1;
                base_d[i] = cdb_data_in;
            end
        end

        if (disp_fire) begin
            valid_d[tail_q] = 1'b1;
            tag_d[tail_q]   = disp_tag_in;
            btag_d[tail_q]  = disp_base_tag_in;
            imm_d[tail_q]   = disp_imm_in;
            f3_d[tail_q]    = disp_funct3_in;
            if (disp_base_rdy_in) begin
                rdy_d[tail_q]  = 1'b1;
                base_d[tail_q] = disp_base_in;
            end else if (cdb_valid_in && cdb_tag_in == disp_base_tag_in) begin
                // Producer broadcasts in the dispatch cycle: take its value directly.
                rdy_d[tail_q]  = 1'b1;
                base_d[tail_q] = cdb_data_in;
            end else begin
                rdy_d[tail_q]  = 1'b0;
                base_d[tail_q] = disp_base_in;
            end
            tail_d = tail_q + PtrW'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (valid_q[head_q] && rdy_q[head_q]) begin
`ifdef LOAD_QUEUE_MISALIGN_EN
                    if (misaligned(head_addr[1:0], f3_q[head_q])) begin
                        state_d        = StWb;
                        res_valid_d    = 1'b1;
                        res_tag_d      = tag_q[head_q];
                        res_data_d     = '0;
                        res_misalign_d = 1'b1;
                    end else begin
                        state_d         = StReq;
                        mem_req_valid_d = 1'b1;
                        mem_addr_d      = {head_addr[XLEN-1:2], 2'b00};
                    end
`else
                    state_d         = StReq;
                    mem_req_valid_d = 1'b1;
                    mem_addr_d      = {head_addr[XLEN-1:2], 2'b00};
`endif
                end
            end
            StReq: begin
                if (mem_req_ready_in) begin
                    mem_req_valid_d = 1'b0;
                    state_d         = StResp;
                end
            end
            StResp: begin
                if (mem_resp_valid_in) begin
                    res_valid_d = 1'b1;
                    res_tag_d   = tag_q[head_q];
                    res_data_d  = extract(mem_resp_data_in, head_addr[1:0], f3_q[head_q]);
`ifdef LOAD_QUEUE_MISALIGN_EN
                    res_misalign_d = 1'b0;
`endif
                    state_d     = StWb;
                end
            end
            StWb: begin
                if (res_ready_in) begin
                    res_valid_d     = 1'b0;
                    valid_d[head_q] = 1'b0;
                    head_d          = head_q + PtrW'(1);
`ifdef LOAD_QUEUE_MISALIGN_EN
                    res_misalign_d  = 1'b0;
`endif
                    state_d         = StIdle;
                end
            end
            StDrain: begin
                if (mem_resp_valid_in) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        unique case ({disp_fire, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        if (flush_in) begin
            valid_d         = '0;
            head_d          = '0;
            tail_d          = '0;
            count_d         = '0;
            res_valid_d     = 1'b0;
            mem_req_valid_d = 1'b0;
`ifdef LOAD_QUEUE_MISALIGN_EN
            res_misalign_d  = 1'b0;
`endif
            // A request the memory already accepted still owes a response; swallow it.
            if ((state_q == StResp && !mem_resp_valid_in) ||
                (state_q == StReq && mem_req_ready_in) ||
                (state_q == StDrain && !mem_resp_valid_in)) begin
                state_d = StDrain;
            end else begin
                state_d = StIdle;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid_q         <= '0;
            rdy_q           <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]  <= '0;
                btag_q[i] <= '0;
                base_q[i] <= '0;
                imm_q[i]  <= '0;
                f3_q[i]   <= '0;
            end
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            state_q         <= StIdle;
            mem_req_valid_q <= 1'b0;
            mem_addr_q      <= '0;
            res_valid_q     <= 1'b0;
            res_tag_q       <= '0;
            res_data_q      <= '0;
`ifdef LOAD_QUEUE_MISALIGN_EN
            res_misalign_q  <= 1'b0;
`endif
        end else begin
            valid_q         <= valid_d;
            rdy_q           <= rdy_d;
            tag_q           <= tag_d;
            btag_q          <= btag_d;
            base_q          <= base_d;
            imm_q           <= imm_d;
            f3_q            <= f3_d;
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            state_q         <= state_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_addr_q      <= mem_addr_d;
            res_valid_q     <= res_valid_d;
            res_tag_q       <= res_tag_d;
            res_data_q      <= res_data_d;
`ifdef LOAD_QUEUE_MISALIGN_EN
            res_misalign_q  <= res_misalign_d;
`endif
        end
    end

    assign mem_req_valid_out = mem_req_valid_q;
    assign mem_addr_out      = mem_addr_q;
    assign res_valid_out     = res_valid_q;
    assign res_tag_out       = res_tag_q;
    assign res_data_out      = res_data_q;
    assign count_out         = count_q;
`ifdef LOAD_QUEUE_MISALIGN_EN
    assign res_misalign_out  = res_misalign_q;
`endif

endmodule

// File: tb/tb_load_queue.sv
// Directed bench for load_queue: a scoreboard queue holds expected {tag, data} per dispatched
// load and is popped when the DUT hands a result to the arbiter.
`timescale 1ns / 1ps

module tb_load_queue;

    localparam int unsigned ENTRIES = 4;
    localparam int unsigned TAG_W   = 4;
    localparam int unsigned XLEN    = 32;

    logic             clk_in = 1'b0;
    logic             rst_n_in;
    logic             flush_in;
    logic             disp_valid_in;
    logic             disp_ready_out;
    logic [TAG_W-1:0] disp_tag_in;
    logic             disp_base_rdy_in;
    logic [XLEN-1:0]  disp_base_in;
    logic [TAG_W-1:0] disp_base_tag_in;
    logic [XLEN-1:0]  disp_imm_in;
    logic [2:0]       disp_funct3_in;
    logic             cdb_valid_in;
    logic [TAG_W-1:0] cdb_tag_in;
    logic [XLEN-1:0]  cdb_data_in;
    logic             mem_req_valid_out;
    logic             mem_req_ready_in;
    logic [XLEN-1:0]  mem_addr_out;
    logic             mem_resp_valid_in;
    logic [XLEN-1:0]  mem_resp_data_in;
    logic             res_valid_out;
    logic             res_ready_in;
    logic [TAG_W-1:0] res_tag_out;
    logic [XLEN-1:0]  res_data_out;
    logic [2:0]       count_out;
`ifdef LOAD_QUEUE_MISALIGN_EN
    logic             res_misalign_out;
`endif

    load_queue #(.ENTRIES(ENTRIES), .TAG_W(TAG_W), .XLEN(XLEN)) dut (
        .clk_in            (clk_in),
        .rst_n_in          (rst_n_in),
        .flush_in          (flush_in),
        .disp_valid_in     (disp_valid_in),
        .disp_ready_out    (disp_ready_out),
        .disp_tag_in       (disp_tag_in),
        .disp_base_rdy_in  (disp_base_rdy_in),
        .disp_base_in      (disp_base_in),
        .disp_base_tag_in  (disp_base_tag_in),
        .disp_imm_in       (disp_imm_in),
        .disp_funct3_in    (disp_funct3_in),
        .cdb_valid_in      (cdb_valid_in),
        .cdb_tag_in        (cdb_tag_in),
        .cdb_data_in       (cdb_data_in),
        .mem_req_valid_out (mem_req_valid_out),
        .mem_req_ready_in  (mem_req_ready_in),
        .mem_addr_out      (mem_addr_out),
        .mem_resp_valid_in (mem_resp_valid_in),
        .mem_resp_data_in  (mem_resp_data_in),
        .res_valid_out     (res_valid_out),
        .res_ready_in      (res_ready_in),
        .res_tag_out       (res_tag_out),
        .res_data_out      (res_data_out),
`ifdef LOAD_QUEUE_MISALIGN_EN
        .res_misalign_out  (res_misalign_out),
`endif
        .count_out         (count_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic disp(input logic [TAG_W-1:0] tag, input logic rdy, input logic [XLEN-1:0] base,
                        input logic [TAG_W-1:0] btag, input logic [XLEN-1:0] imm,
                        input logic [2:0] f3, input logic [XLEN-1:0] exp_data);
        exp_t e;
        check("disp_ready", disp_ready_out, 1);
        disp_valid_in    = 1'b1;
        disp_tag_in      = tag;
        disp_base_rdy_in = rdy;
        disp_base_in     = base;
        disp_base_tag_in = btag;
        disp_imm_in      = imm;
        disp_funct3_in   = f3;
        e.tag  = tag;
        e.data = exp_data;
        sb.push_back(e);
        @(negedge clk_in);
        disp_valid_in = 1'b0;
    endtask

    task automatic serve(input logic [XLEN-1:0] addr, input logic [XLEN-1:0] word,
                         input bit respond);
        bit seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (mem_req_valid_out === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk_in);
        end
        check("req_seen", seen, 1);
        if (seen) begin
            check("req_addr", mem_addr_out, addr);
            @(negedge clk_in);
            check("req_hold_valid", mem_req_valid_out, 1);
            check("req_hold_addr", mem_addr_out, addr);
            mem_req_ready_in = 1'b1;
            @(negedge clk_in);
            mem_req_ready_in = 1'b0;
            check("req_drop", mem_req_valid_out, 0);
            if (respond) begin
                mem_resp_valid_in = 1'b1;
                mem_resp_data_in  = word;
                @(negedge clk_in);
                mem_resp_valid_in = 1'b0;
            end
        end
    endtask

    task automatic get_result(input string name);
        bit   seen = 1'b0;
        exp_t e;
        for (int i = 0; i < 40; i++) begin
            if (res_valid_out === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk_in);
        end
        check({name, "_seen"}, seen, 1);
        check({name, "_sb_nonempty"}, sb.size() > 0, 1);
        if (seen && sb.size() > 0) begin
            e = sb.pop_front();
            check({name, "_tag"}, res_tag_out, e.tag);
            check({name, "_data"}, res_data_out, e.data);
            res_ready_in = 1'b1;
            @(negedge clk_in);
            res_ready_in = 1'b0;
            check({name, "_drop"}, res_valid_out, 0);
        end
    endtask

    task automatic load(input string name, input logic [TAG_W-1:0] tag,
                        input logic [XLEN-1:0] base, input logic [XLEN-1:0] imm,
                        input logic [2:0] f3, input logic [XLEN-1:0] addr,
                        input logic [XLEN-1:0] word, input logic [XLEN-1:0] exp_data);
        disp(tag, 1'b1, base, '0, imm, f3, exp_data);
        serve(addr, word, 1'b1);
        get_result(name);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit flag;
        rst_n_in          = 1'b0;
        flush_in          = 1'b0;
        disp_valid_in     = 1'b0;
        disp_tag_in       = '0;
        disp_base_rdy_in  = 1'b0;
        disp_base_in      = '0;
        disp_base_tag_in  = '0;
        disp_imm_in       = '0;
        disp_funct3_in    = '0;
        cdb_valid_in      = 1'b0;
        cdb_tag_in        = '0;
        cdb_data_in       = '0;
        mem_req_ready_in  = 1'b0;
        mem_resp_valid_in = 1'b0;
        mem_resp_data_in  = '0;
        res_ready_in      = 1'b0;
        repeat (3) @(negedge clk_in);
        rst_n_in = 1'b1;
        @(negedge clk_in);

        // Reset state
        check("rst_count", count_out, 0);
        check("rst_disp_ready", disp_ready_out, 1);
        check("rst_req_valid", mem_req_valid_out, 0);
        check("rst_res_valid", res_valid_out, 0);
        check("rst_addr", mem_addr_out, 0);
        check("rst_res_tag", res_tag_out, 0);
        check("rst_res_data", res_data_out, 0);

        // Basic LW
        disp(4'd3, 1'b1, 32'h100, '0, 32'd4, 3'b010, 32'hDEADBEEF);
        check("lw_count_one", count_out, 1);
        serve(32'h104, 32'hDEADBEEF, 1'b1);
        get_result("lw");
        check("lw_count_zero", count_out, 0);

        // Extraction cases
        load("lb_neg", 4'd4, 32'h100, 32'd3, 3'b000, 32'h100, 32'h80FFFFFF, 32'hFFFFFF80);
        load("lbu", 4'd5, 32'h100, 32'd3, 3'b100, 32'h100, 32'h80FFFFFF, 32'h00000080);
        load("lhu", 4'd6, 32'h100, 32'd2, 3'b101, 32'h100, 32'h80FFFFFF, 32'h000080FF);
        load("lh_neg", 4'd7, 32'h100, 32'd2, 3'b001, 32'h100, 32'h80FFFFFF, 32'hFFFF80FF);
        load("lb_lane1", 4'd2, 32'h100, 32'd1, 3'b000, 32'h100, 32'h12345678, 32'h00000056);
        load("lh_lane0", 4'd8, 32'h100, 32'd0, 3'b001, 32'h100, 32'h12348001, 32'hFFFF8001);
        load("lw_negimm", 4'd9, 32'h200, 32'hFFFFFFFC, 3'b010, 32'h1FC, 32'hCAFEF00D,
             32'hCAFEF00D);
        load("rsvd_f3", 4'd10, 32'h40, 32'd1, 3'b011, 32'h40, 32'h01020304, 32'h01020304);

        // CDB wakeup keeps program order
        disp(4'd1, 1'b0, 32'h0, 4'd7, 32'h10, 3'b010, 32'hAAAA5555);
        disp(4'd2, 1'b1, 32'h300, '0, 32'h0, 3'b010, 32'h12340000);
        flag = 1'b0;
        repeat (6) begin
            if (mem_req_valid_out !== 1'b0) flag = 1'b1;
            @(negedge clk_in);
        end
        check("cdb_wait_no_req", flag, 0);
        cdb_valid_in = 1'b1;
        cdb_tag_in   = 4'd7;
        cdb_data_in  = 32'h200;
        @(negedge clk_in);
        cdb_valid_in = 1'b0;
        serve(32'h210, 32'hAAAA5555, 1'b1);
        get_result("cdb_first");
        serve(32'h300, 32'h12340000, 1'b1);
        get_result("cdb_second");

        // Dispatch-cycle CDB bypass
        cdb_valid_in = 1'b1;
        cdb_tag_in   = 4'd9;
        cdb_data_in  = 32'h400;
        disp(4'd6, 1'b0, 32'h0, 4'd9, 32'h8, 3'b010, 32'h0BADCAFE);
        cdb_valid_in = 1'b0;
        serve(32'h408, 32'h0BADCAFE, 1'b1);
        get_result("bypass");

        // Fill to capacity with the arbiter stalled
        for (int i = 0; i < 4; i++) begin
            disp(TAG_W'(8 + i), 1'b1, 32'h700 + 32'(i * 16), '0, 32'h0, 3'b010,
                 32'h7000_0000 + 32'(i));
        end
        check("full_count", count_out, 4);
        check("full_not_ready", disp_ready_out, 0);
        serve(32'h700, 32'h7000_0000, 1'b1);
        disp_valid_in = 1'b1;
        disp_tag_in   = 4'd15;
        @(negedge clk_in);
        disp_valid_in = 1'b0;
        check("full_reject_count", count_out, 4);
        get_result("full_pop");
        check("after_pop_ready", disp_ready_out, 1);
        check("after_pop_count", count_out, 3);
        for (int i = 1; i < 4; i++) begin
            serve(32'h700 + 32'(i * 16), 32'h7000_0000 + 32'(i), 1'b1);
            get_result("full_drain");
        end
        check("full_empty", count_out, 0);

        // Flush while waiting for a response, with a simultaneous dispatch
        disp(4'd12, 1'b1, 32'h500, '0, 32'h0, 3'b010, 32'h55555555);
        serve(32'h500, 32'h0, 1'b0);
        flush_in      = 1'b1;
        disp_valid_in = 1'b1;
        disp_tag_in   = 4'd14;
        disp_base_rdy_in = 1'b1;
        sb.delete();
        @(negedge clk_in);
        flush_in      = 1'b0;
        disp_valid_in = 1'b0;
        check("flush_count", count_out, 0);
        check("flush_res_valid", res_valid_out, 0);
        check("flush_req_valid", mem_req_valid_out, 0);
        disp(4'd13, 1'b1, 32'h600, '0, 32'h0, 3'b010, 32'h13131313);
        flag = 1'b0;
        repeat (4) begin
            if (mem_req_valid_out !== 1'b0) flag = 1'b1;
            @(negedge clk_in);
        end
        check("drain_no_req", flag, 0);
        check("drain_count", count_out, 1);
        mem_resp_valid_in = 1'b1;
        mem_resp_data_in  = 32'hBAD0BAD0;
        @(negedge clk_in);
        mem_resp_valid_in = 1'b0;
        check("late_resp_no_res", res_valid_out, 0);
        serve(32'h600, 32'h13131313, 1'b1);
        get_result("post_flush");

`ifdef LOAD_QUEUE_MISALIGN_EN
        // Misaligned LW completes without touching memory
        disp(4'd4, 1'b1, 32'h100, '0, 32'd2, 3'b010, 32'h0);
        flag = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mem_req_valid_out !== 1'b0) flag = 1'b1;
            if (res_valid_out === 1'b1) break;
            @(negedge clk_in);
        end
        check("misalign_no_req", flag, 0);
        check("misalign_flag", res_misalign_out, 1);
        get_result("misalign");
        check("misalign_clear", res_misalign_out, 0);
`endif

        // Asynchronous reset in the middle of a request
        disp(4'd5, 1'b1, 32'h800, '0, 32'h0, 3'b010, 32'h0);
        flag = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mem_req_valid_out === 1'b1) begin
                flag = 1'b1;
                break;
            end
            @(negedge clk_in);
        end
        check("midrst_req_seen", flag, 1);
        rst_n_in = 1'b0;
        #1;
        check("midrst_req_valid", mem_req_valid_out, 0);
        check("midrst_addr", mem_addr_out, 0);
        check("midrst_count", count_out, 0);
        check("midrst_disp_ready", disp_ready_out, 1);
        sb.delete();
        @(negedge clk_in);
        rst_n_in = 1'b1;
        @(negedge clk_in);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
